tt_mux_ctrl_driver: RTL and testbench

Initiator for the Tiny Tapeout project-mux control interface. It drives `ctrl_sel_rst_n`, `ctrl_sel_inc` and `ctrl_ena` so that the mux address counter points at a requested project, then enables that project. It sits on the management side of the chip, between a local requester (test bench, management SoC or config FSM) and the mux control pads. It replaces hand-toggling of those pins in benches.

---
 rtl/tt_mux_ctrl_pkg.sv | 22 ++
 rtl/tt_mux_ctrl_phase_timer.sv | 31 +++
 rtl/tt_mux_ctrl_driver.sv | 113 +++++++++++
 tb/tb_tt_mux_ctrl_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_mux_ctrl_pkg.sv
// Shared types and defaults for the Tiny Tapeout project-mux control driver.
// The state encoding is fixed so that the state register is stable across tools.
package tt_mux_ctrl_pkg;

  localparam int ADDR_W_DEFAULT       = 10;
  localparam int PULSE_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST_LO = 3'd1,
    RST_HI = 3'd2,
    INC_HI = 3'd3,
    INC_LO = 3'd4,
    ACTIVE = 3'd5
  } mux_ctrl_state_t;

  // True for every state that belongs to a running selection sequence.
  function automatic logic is_seq_state(input mux_ctrl_state_t s);
    return (s == RST_LO) || (s == RST_HI) || (s == INC_HI) || (s == INC_LO);
  endfunction

endpackage

// File: rtl/tt_mux_ctrl_phase_timer.sv
// Phase-length down-counter: reloaded on each FSM state entry, flags the
// last cycle of a PULSE_CYCLES-long phase.
module tt_mux_ctrl_phase_timer #(
  parameter int PULSE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic phase_end
);

  localparam int                CNT_W    = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(PULSE_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign phase_end = (count == '0);

endmodule

// File: rtl/tt_mux_ctrl_driver.sv
// Drives the Tiny Tapeout mux control pins: resets the mux address counter,
// pulses the increment strobe N times, then enables the selected project.
module tt_mux_ctrl_driver
  import tt_mux_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              disable_req,
  output logic              busy,
  output logic              done,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  mux_ctrl_state_t   state;
  mux_ctrl_state_t   next_state;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] remaining_next;
  logic              phase_end;
  logic              state_load;
  logic              start_ok;
  logic              disable_ok;

  // Requests are only honoured outside a running sequence; start beats disable.
  assign start_ok   = start && ((state == IDLE) || (state == ACTIVE));
  assign disable_ok = disable_req && !start && (state == ACTIVE);

  // NOTE: both outputs of this block get a default first, so no path through
  // the case statement can leave them unassigned and infer a latch.
  always_comb begin
    next_state     = state;
    remaining_next = remaining;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          next_state     = RST_LO;
          remaining_next = addr;
        end
      end
      RST_LO: begin
        if (phase_end) next_state = RST_HI;
      end
      RST_HI: begin
        if (phase_end) next_state = (remaining == '0) ? ACTIVE : INC_HI;
      end
      INC_HI: begin
        if (phase_end) next_state = INC_LO;
      end
      INC_LO: begin
        // remaining is nonzero here, so the decrement can never wrap.
        if (phase_end) begin
          remaining_next = remaining - 1'b1;
          next_state     = (remaining == ADDR_W'(1)) ? ACTIVE : INC_HI;
        end
      end
      ACTIVE: begin
        if (start_ok) begin
          next_state     = RST_LO;
          remaining_next = addr;
        end else if (disable_ok) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Every transition is a change of state, so a change reloads the phase timer.
  assign state_load = (next_state != state);

  tt_mux_ctrl_phase_timer #(
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_load),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= next_state;
      remaining <= remaining_next;
    end
  end

  // Outputs are decoded from next_state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      ctrl_sel_rst_n <= (next_state != RST_LO);
      ctrl_sel_inc   <= (next_state == INC_HI);
      ctrl_ena       <= (next_state == ACTIVE);
      busy           <= is_seq_state(next_state);
      done           <= (next_state == ACTIVE) && (state != ACTIVE);
    end
  end

endmodule

// File: tb/tb_tt_mux_ctrl_driver.sv
// Directed bench for tt_mux_ctrl_driver (P=2, ADDR_W=10) with a behavioural
// model of the mux address counter driven by the control pins.
module tb_tt_mux_ctrl_driver;

  localparam int P = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] addr;
  logic       disable_req;
  logic       busy;
  logic       done;
  logic       ctrl_sel_rst_n;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic [9:0] mux_cnt  = '0;
  logic       inc_prev = 1'b0;

  tt_mux_ctrl_driver #(
    .ADDR_W       (10),
    .PULSE_CYCLES (P)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .addr           (addr),
    .disable_req    (disable_req),
    .busy           (busy),
    .done           (done),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mux address counter as the chip sees it: cleared while sel_rst_n is low,
  // advanced on each rising edge of sel_inc.
  always @(negedge clk) begin
    if (!ctrl_sel_rst_n) mux_cnt <= '0;
    else if (ctrl_sel_inc && !inc_prev) mux_cnt <= mux_cnt + 10'd1;
    inc_prev <= ctrl_sel_inc;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!ctrl_sel_rst_n && ctrl_sel_inc) viol <= viol + 1;
      if (ctrl_ena && busy) viol <= viol + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string name);
    logic [4:0] got;
    got = {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy};
    n_checks++;
    if (got !== 5'b10000) begin
      n_fail++;
      $display("FAIL %s: {rst_n,inc,ena,done,busy} got %b expected 10000", name, got);
    end
  endtask

  // Start a selection of address a in cycle 0 and check all outputs in each
  // cycle up to one past the expected enable. Optionally drive a second
  // request (start/addr/disable) in cycle inj_cycle.
  task automatic run_sequence(input string name, input logic [9:0] a, input logic dis0,
                              input int inj_cycle, input logic inj_start,
                              input logic [9:0] inj_addr, input logic inj_dis);
    int         e;
    logic       r, i, en, d, b;
    logic [4:0] got, exp;
    e = 1 + 2*P + 2*P*int'(a);
    start = 1'b1; addr = a; disable_req = dis0;
    for (int c = 1; c <= e + 1; c++) begin
      step();
      start = 1'b0; disable_req = 1'b0; addr = ~a;
      r   = !(c <= P);
      i   = (c > 2*P) && (c < e) && (((c - 2*P - 1) % (2*P)) < P);
      en  = (c >= e);
      d   = (c == e);
      b   = (c < e);
      exp = {r, i, en, d, b};
      got = {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: {rst_n,inc,ena,done,busy} got %b expected %b",
                 name, c, got, exp);
      end
      if (c == inj_cycle) begin
        start = inj_start; addr = inj_addr; disable_req = inj_dis;
      end
    end
    n_checks++;
    if (mux_cnt !== a) begin
      n_fail++;
      $display("FAIL %s mux_count: got %0d expected %0d", name, mux_cnt, a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; addr = '0; disable_req = 1'b0;
    #1 rst_n = 1'b0;
    step();
    step();
    expect_idle("reset_held");
    rst_n = 1'b1;
    step();
    expect_idle("after_reset");
    disable_req = 1'b1;
    step();
    disable_req = 1'b0;
    expect_idle("disable_in_idle");
    step();
    expect_idle("disable_in_idle_2");
  endtask

  task automatic test_addr_zero();
    run_sequence("addr0", 10'd0, 1'b0, -1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_addr_five();
    run_sequence("addr5_from_active", 10'd5, 1'b0, -1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_sequence("addr3_ignore_7", 10'd3, 1'b0, 4, 1'b1, 10'd7, 1'b0);
  endtask

  task automatic test_disable();
    disable_req = 1'b1;
    step();
    disable_req = 1'b0;
    expect_idle("disable_in_active");
    step();
    expect_idle("stays_idle");
    run_sequence("disable_while_busy", 10'd2, 1'b0, 3, 1'b0, 10'd9, 1'b1);
    run_sequence("start_beats_disable", 10'd4, 1'b1, -1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid_sequence();
    logic [4:0] got;
    start = 1'b1; addr = 10'd1023;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0; addr = '0;
    end
    n_checks++;
    if (ctrl_sel_inc !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_inc_hi: inc=%b busy=%b expected inc=1 busy=1", ctrl_sel_inc, busy);
    end
    rst_n = 1'b0;
    #1;
    expect_idle("async_reset_immediate");
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      got = {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy};
      n_checks++;
      if (got !== 5'b10000) begin
        n_fail++;
        $display("FAIL no_done_after_reset cycle %0d: got %b expected 10000", c, got);
      end
    end
    run_sequence("addr1023_full", 10'd1023, 1'b0, -1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_invariants();
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL pin_invariants: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_addr_zero();
    test_addr_five();
    test_start_while_busy();
    test_disable();
    test_reset_mid_sequence();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
